sha_depadder: RTL
=================

Name: sha_depadder

Overview:
- Inverse of the SHA-256 single-block padding stage: accepts one padded 512-bit block, validates the padding, and returns the original message bits and the 64-bit length.
- Used on the verification/loopback path and by the host-side checker to confirm that padded blocks are well formed before they reach the hash core.
- Scans the zero-pad region serially, BITS_PER_CYCLE bits per clock, under a multi-cycle FSM with valid/ready handshakes on both sides.

Parameters:
- BITS_PER_CYCLE, 8: pad bits checked per SCAN cycle. Legal values: 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  block_in is valid.
- in_ready  output  1  block can be accepted; high only in IDLE.
- block_in  input  512  padded block.
  - Message occupies [511:512-L].
  - Pad '1' is at bit 511-L.
  - Zeros occupy [510-L:64].
  - Length L occupies [63:0].
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- msg_out  output  447  equals block[511:65] with all bits below the message forced to 0. The message is left-aligned at msg_out[446].
- len_out  output  64  L as read from block[63:0].
- err  output  1  padding invalid. Meaningful only while out_valid is high.

Behaviour:
- Reset values: in_ready=0 in the reset cycle, then 1; out_valid=0; msg_out=0; len_out=0; err=0. The FSM goes to IDLE and the scan counter is cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch block_in into an internal register and go to CHECK.
- CHECK (1 cycle):
  - If block[63:0] > 447: set err and go to DONE.
  - Else if block[511-L] != 1: set err and go to DONE.
  - Else: load pos = 510-L and go to SCAN.
  - Special case L=447: the zero region is empty, so go directly to DONE with err=0.
- SCAN:
  - Each cycle, check bits [pos : max(pos-BITS_PER_CYCLE+1, 64)] for zero. The final chunk is masked so bits below 64 are never tested.
  - Any 1 found: set err, go to DONE immediately. The remaining bits are not scanned.
  - When the chunk reaches bit 64: go to DONE.
- DONE:
  - out_valid=1. msg_out and len_out are driven from the latched block.
  - msg_out and len_out are driven even when err=1. In the L>447 case, msg_out is the full block[511:65] unmasked.
  - When out_valid&out_ready: drop out_valid and return to IDLE. in_ready rises the following cycle.
- Latency for a valid block, from acceptance to out_valid: 2 + ceil((447-L)/BITS_PER_CYCLE) cycles.
- Backpressure: outputs are stable while out_valid=1 and out_ready=0. No new block is accepted until the result is consumed.
- Simultaneous events: in_valid is ignored outside IDLE. In DONE, out_ready takes effect on the clock edge it is sampled.
- Reset mid-operation: rst in any state aborts the operation and restores all reset values on the next edge. No partial result is emitted.
- Width rules:
  - L compare uses the full 64 bits; any upper bit set means err.
  - pos is a 9-bit unsigned counter and never wraps below 64.

Optional Feature:
- Macro: SHA_DEPAD_ERRCODE_EN.
- Defined: adds output port err_code[1:0], valid with out_valid.
  - 00 ok.
  - 01 length > 447.
  - 10 pad '1' missing.
  - 11 nonzero bit in the pad region.
  - err = |err_code.
- Not defined: port absent; only err is reported. All other behaviour is identical.

Test Plan:
- "abc": block = 0x61626380 followed by zeros, with bits [63:0]=0x18. Expected: err=0, len_out=24, msg_out[446:423]=0x616263, rest 0; out_valid at cycle 2+ceil(423/8)=55.
- L=447: message all ones, bit 64=1, length=447. Expected: out_valid 2 cycles after accept, err=0, msg_out all ones.
- L=0: bit 511=1, all other bits 0. Expected: err=0, len_out=0, msg_out=0, latency 2+56=58 (BITS_PER_CYCLE=8).
- Length 448, then a block with a stray 1 at bit 100 and L=24. Expected: both give err=1, with err_code 01 and 11 respectively. The stray-bit case ends SCAN early.
- Hold out_ready=0 for 10 cycles in DONE. Expected: outputs stable, in_ready=0, and a new in_valid is ignored. Then pulse out_ready; in_ready=1 on the next cycle.
- Assert rst during SCAN. Expected: next cycle out_valid=0 and msg_out=0; a fresh "abc" block afterwards completes correctly.

Source files
------------

// File: rtl/sha_depadder_if.sv
// rtl/sha_depadder_if.sv - block-in / result-out handshake bundle for sha_depadder
// err_code is present only when SHA_DEPAD_ERRCODE_EN is defined.
interface sha_depadder_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_in;
  logic         out_valid;
  logic         out_ready;
  logic [446:0] msg_out;
  logic [63:0]  len_out;
  logic         err;
`ifdef SHA_DEPAD_ERRCODE_EN
  logic [1:0]   err_code;
`endif

  modport slave (
    input  in_valid, block_in, out_ready,
    output in_ready, out_valid, msg_out, len_out, err
`ifdef SHA_DEPAD_ERRCODE_EN
    , output err_code
`endif
  );

  modport master (
    output in_valid, block_in, out_ready,
    input  in_ready, out_valid, msg_out, len_out, err
`ifdef SHA_DEPAD_ERRCODE_EN
    , input err_code
`endif
  );
endinterface

// File: rtl/sha_depadder.sv
// rtl/sha_depadder.sv - validates single-block SHA-256 padding and returns message and length
// Optional macro SHA_DEPAD_ERRCODE_EN adds the 2-bit err_code output.
module sha_depadder #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic          clk,
  input  logic          rst,
  sha_depadder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t       state_q, state_d;
  logic [511:0] block_q, block_d;
  logic [8:0]   pos_q, pos_d;
  logic [1:0]   err_code_q, err_code_d;
  logic         in_ready_q, in_ready_d;

  logic [8:0]   len9;
  logic         len_big;
  logic [8:0]   pad_idx;
  logic         pad_bit;
  logic [8:0]   span;
  logic [8:0]   bit_idx;
  logic         chunk_nz;
  logic         last_chunk;
  logic [8:0]   shamt;
  logic [446:0] msg_mask;
  logic         done;

  always_comb begin
    len9     = block_q[8:0];
    len_big  = (|block_q[63:9]) || (len9 > 9'd447);
    pad_idx  = 9'd511 - len9;
    pad_bit  = block_q[pad_idx];
    // span = number of chunk bits above 64, so the final chunk never tests the length field
    span     = pos_q - 9'd64;
    chunk_nz = 1'b0;
    bit_idx  = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      bit_idx = pos_q - 9'(j);
      if ((9'(j) <= span) && block_q[bit_idx]) chunk_nz = 1'b1;
    end
    last_chunk = (pos_q <= 9'(63 + BITS_PER_CYCLE));
    shamt      = 9'd447 - len9;
    msg_mask   = len_big ? {447{1'b1}} : ({447{1'b1}} << shamt);
  end

  always_comb begin
    state_d    = state_q;
    block_d    = block_q;
    pos_d      = pos_q;
    err_code_d = err_code_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          block_d    = bus.block_in;
          err_code_d = 2'b00;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (len_big) begin
          err_code_d = 2'b01;
          state_d    = DONE;
        end else if (!pad_bit) begin
          err_code_d = 2'b10;
          state_d    = DONE;
        end else if (len9 == 9'd447) begin
          state_d = DONE;
        end else begin
          pos_d   = 9'd510 - len9;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_nz) begin
          err_code_d = 2'b11;
          state_d    = DONE;
        end else if (last_chunk) begin
          state_d = DONE;
        end else begin
          pos_d = pos_q - 9'(BITS_PER_CYCLE);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      block_q    <= '0;
      pos_q      <= '0;
      err_code_q <= 2'b00;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      pos_q      <= pos_d;
      err_code_q <= err_code_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign done          = (state_q == DONE);
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = done;
  assign bus.msg_out   = done ? (block_q[511:65] & msg_mask) : '0;
  assign bus.len_out   = done ? block_q[63:0] : '0;
  assign bus.err       = done && (|err_code_q);
`ifdef SHA_DEPAD_ERRCODE_EN
  assign bus.err_code  = done ? err_code_q : 2'b00;
`endif

endmodule
